// File: rtl/wf_instr_occupancy.sv
// rtl/wf_instr_occupancy.sv - per-wavefront decoded-but-unissued instruction occupancy counters
// Optional sticky overflow/underflow flags: define WF_OCC_ERR_CHECK_EN.
module wf_instr_occupancy #(
  parameter int NUM_WF      = 40,
  parameter int WF_ID_W     = 6,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = 2,
  parameter int ISSUE_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           f_decode_valid,
  input  logic                           f_decode_wf_halt,
  input  logic                           f_decode_barrier,
  input  logic                           f_decode_waitcnt,
  input  logic [WF_ID_W-1:0]             f_decode_wfid,
  input  logic [ISSUE_PORTS-1:0]         issued_valid,
  input  logic [ISSUE_PORTS*WF_ID_W-1:0] issued_wfid,
  input  logic                           f_salu_branch_en,
  input  logic                           f_salu_branch_taken,
  input  logic [WF_ID_W-1:0]             f_salu_branch_wfid,
  output logic [NUM_WF-1:0]              valid_entry_out,
  output logic [NUM_WF-1:0]              full_entry_out,
  output logic [NUM_WF*CNT_W-1:0]        entry_count_out
`ifdef WF_OCC_ERR_CHECK_EN
  ,
  output logic [NUM_WF-1:0]              occ_overflow_err,
  output logic [NUM_WF-1:0]              occ_underflow_err
`endif
);

  localparam logic signed [CNT_W+1:0] DEPTH_S = (CNT_W+2)'(DEPTH);
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(DEPTH);

  logic [CNT_W-1:0]        cnt_q [NUM_WF];
  logic [CNT_W-1:0]        cnt_d [NUM_WF];
  logic                    inc_w;
  logic                    flush_w;
  logic [CNT_W+1:0]        dec_n;
  logic signed [CNT_W+1:0] sum;
  logic                    decode_buffered;
  logic                    branch_flush;

`ifdef WF_OCC_ERR_CHECK_EN
  logic [NUM_WF-1:0] ovf_ev;
  logic [NUM_WF-1:0] udf_ev;
`endif

  // halt/barrier/waitcnt are consumed at decode and never occupy a slot
  assign decode_buffered = f_decode_valid & ~f_decode_wf_halt & ~f_decode_barrier & ~f_decode_waitcnt;
  assign branch_flush    = f_salu_branch_en & f_salu_branch_taken;

  always_comb begin
    inc_w   = 1'b0;
    flush_w = 1'b0;
    dec_n   = '0;
    sum     = '0;
`ifdef WF_OCC_ERR_CHECK_EN
    ovf_ev  = '0;
    udf_ev  = '0;
`endif
    for (int w = 0; w < NUM_WF; w++) begin
      inc_w   = decode_buffered & (32'(f_decode_wfid) == w);
      flush_w = branch_flush & (32'(f_salu_branch_wfid) == w);
      dec_n   = '0;
      for (int p = 0; p < ISSUE_PORTS; p++) begin
        if (issued_valid[p] && (32'(issued_wfid[p*WF_ID_W +: WF_ID_W]) == w))
          dec_n = dec_n + (CNT_W+2)'(1);
      end
      sum = $signed({2'b00, cnt_q[w]}) + $signed({{(CNT_W+1){1'b0}}, inc_w}) - $signed(dec_n);
      // A taken branch discards wrong-path decodes and any same-cycle issue
      if (flush_w) begin
        cnt_d[w] = '0;
      end else if (sum < 0) begin
        cnt_d[w] = '0;
`ifdef WF_OCC_ERR_CHECK_EN
        udf_ev[w] = 1'b1;
`endif
      end else if (sum > DEPTH_S) begin
        cnt_d[w] = CNT_MAX;
`ifdef WF_OCC_ERR_CHECK_EN
        ovf_ev[w] = 1'b1;
`endif
      end else begin
        cnt_d[w] = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WF; w++) cnt_q[w] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar w = 0; w < NUM_WF; w++) begin : g_out
    assign valid_entry_out[w]                 = |cnt_q[w];
    assign full_entry_out[w]                  = (cnt_q[w] == CNT_MAX);
    assign entry_count_out[w*CNT_W +: CNT_W]  = cnt_q[w];
  end

`ifdef WF_OCC_ERR_CHECK_EN
  // Sticky until reset; a flush leaves them untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_overflow_err  <= '0;
      occ_underflow_err <= '0;
    end else begin
      occ_overflow_err  <= occ_overflow_err | ovf_ev;
      occ_underflow_err <= occ_underflow_err | udf_ev;
`ifndef SYNTHESIS
      for (int w = 0; w < NUM_WF; w++) begin
        if (ovf_ev[w]) $display("wf_instr_occupancy: overflow error on wavefront %0d", w);
        if (udf_ev[w]) $display("wf_instr_occupancy: underflow error on wavefront %0d", w);
      end
`endif
    end
  end
`endif

endmodule

// File: tb/tb_wf_instr_occupancy.sv
// tb/tb_wf_instr_occupancy.sv - directed plus randomized bench for wf_instr_occupancy
module tb_wf_instr_occupancy;
  localparam int NUM_WF = 40;
  localparam int WF_ID_W = 6;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int IP = 2;

  logic clk = 1'b0;
  logic rst;
  logic dv, halt, bar, wc;
  logic [WF_ID_W-1:0] dwf;
  logic [IP-1:0] iv;
  logic [IP*WF_ID_W-1:0] iwf;
  logic be, bt;
  logic [WF_ID_W-1:0] bwf;
  logic [NUM_WF-1:0] valid_o, full_o;
  logic [NUM_WF*CNT_W-1:0] cnt_o;
`ifdef WF_OCC_ERR_CHECK_EN
  logic [NUM_WF-1:0] ovf_o, udf_o;
  logic [NUM_WF-1:0] m_ovf, m_udf;
`endif

  int m_cnt[NUM_WF];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wf_instr_occupancy #(
    .NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .ISSUE_PORTS(IP)
  ) dut (
    .clk(clk), .rst(rst),
    .f_decode_valid(dv), .f_decode_wf_halt(halt), .f_decode_barrier(bar),
    .f_decode_waitcnt(wc), .f_decode_wfid(dwf),
    .issued_valid(iv), .issued_wfid(iwf),
    .f_salu_branch_en(be), .f_salu_branch_taken(bt), .f_salu_branch_wfid(bwf),
    .valid_entry_out(valid_o), .full_entry_out(full_o), .entry_count_out(cnt_o)
`ifdef WF_OCC_ERR_CHECK_EN
    , .occ_overflow_err(ovf_o), .occ_underflow_err(udf_o)
`endif
  );

  task automatic idle();
    rst = 0; dv = 0; halt = 0; bar = 0; wc = 0; dwf = '0;
    iv = '0; iwf = '0; be = 0; bt = 0; bwf = '0;
  endtask

  // Reference: occupancy = buffered decodes minus issues, clamped to [0, DEPTH]
  task automatic model_step();
    int inc, dec, s;
    bit fl;
    for (int w = 0; w < NUM_WF; w++) begin
      inc = (dv && !halt && !bar && !wc && int'(dwf) == w) ? 1 : 0;
      dec = 0;
      for (int p = 0; p < IP; p++)
        if (iv[p] && int'(iwf[p*WF_ID_W +: WF_ID_W]) == w) dec++;
      fl = be && bt && int'(bwf) == w;
      s = m_cnt[w] + inc - dec;
      if (rst) begin
        m_cnt[w] = 0;
      end else if (fl) begin
        m_cnt[w] = 0;
      end else begin
`ifdef WF_OCC_ERR_CHECK_EN
        if (s < 0) m_udf[w] = 1'b1;
        if (s > DEPTH) m_ovf[w] = 1'b1;
`endif
        m_cnt[w] = (s < 0) ? 0 : (s > DEPTH) ? DEPTH : s;
      end
    end
`ifdef WF_OCC_ERR_CHECK_EN
    if (rst) begin m_ovf = '0; m_udf = '0; end
`endif
  endtask

  task automatic check_all(input string tag);
    logic [NUM_WF*CNT_W-1:0] e_cnt;
    logic [NUM_WF-1:0] e_v, e_f;
    for (int w = 0; w < NUM_WF; w++) begin
      e_cnt[w*CNT_W +: CNT_W] = CNT_W'(m_cnt[w]);
      e_v[w] = (m_cnt[w] != 0);
      e_f[w] = (m_cnt[w] == DEPTH);
    end
    vectors++;
    assert (cnt_o === e_cnt) else begin miscompares++; $error("FAIL %s count obs=%h exp=%h", tag, cnt_o, e_cnt); end
    vectors++;
    assert (valid_o === e_v) else begin miscompares++; $error("FAIL %s valid obs=%h exp=%h", tag, valid_o, e_v); end
    vectors++;
    assert (full_o === e_f) else begin miscompares++; $error("FAIL %s full obs=%h exp=%h", tag, full_o, e_f); end
`ifdef WF_OCC_ERR_CHECK_EN
    vectors++;
    assert (ovf_o === m_ovf) else begin miscompares++; $error("FAIL %s ovf obs=%h exp=%h", tag, ovf_o, m_ovf); end
    vectors++;
    assert (udf_o === m_udf) else begin miscompares++; $error("FAIL %s udf obs=%h exp=%h", tag, udf_o, m_udf); end
`endif
  endtask

  // Apply current inputs at one edge, then compare one step later
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    idle();
  endtask

  task automatic chk_cnt(input string tag, input int w, input int exp);
    logic [CNT_W-1:0] e;
    e = CNT_W'(exp);
    vectors++;
    assert (cnt_o[w*CNT_W +: CNT_W] === e) else begin
      miscompares++; $error("FAIL %s obs=%0d exp=%0d", tag, cnt_o[w*CNT_W +: CNT_W], e);
    end
  endtask

  task automatic decode(input int w);
    dv = 1; dwf = WF_ID_W'(w);
  endtask

  task automatic issue(input int p, input int w);
    iv[p] = 1'b1; iwf[p*WF_ID_W +: WF_ID_W] = WF_ID_W'(w);
  endtask

  initial begin
    for (int w = 0; w < NUM_WF; w++) m_cnt[w] = 0;
`ifdef WF_OCC_ERR_CHECK_EN
    m_ovf = '0; m_udf = '0;
`endif
    idle();
    rst = 1; @(posedge clk); rst = 1; tick("reset");
    vectors++;
    assert (cnt_o === '0 && valid_o === '0 && full_o === '0) else begin
      miscompares++; $error("FAIL reset_zero obs=%h exp=0", cnt_o);
    end
    tick("idle0"); tick("idle1");

    decode(5); tick("fill1"); chk_cnt("fill1_c5", 5, 1);
    decode(5); tick("fill2"); chk_cnt("fill2_c5", 5, 2);
    vectors++;
    assert (full_o[5] === 1'b1) else begin miscompares++; $error("FAIL full5 obs=%b exp=1", full_o[5]); end
    issue(0, 5); tick("drain1"); chk_cnt("drain1_c5", 5, 1);
    issue(1, 5); tick("drain2"); chk_cnt("drain2_c5", 5, 0);
    vectors++;
    assert (valid_o[5] === 1'b0) else begin miscompares++; $error("FAIL valid5 obs=%b exp=0", valid_o[5]); end

    decode(3); tick("d3a"); decode(3); tick("d3b");
    issue(0, 3); issue(1, 3); tick("dual"); chk_cnt("dual_c3", 3, 0);
    decode(3); tick("d3c"); decode(3); tick("d3d");
    issue(0, 3); issue(1, 3); decode(3); tick("dual_dec"); chk_cnt("dual_dec_c3", 3, 1);

    decode(7); tick("d7");
    decode(7); be = 1; bt = 1; bwf = 7; tick("flush7"); chk_cnt("flush7_c7", 7, 0);
    decode(7); tick("d7b");
    decode(7); be = 1; bt = 0; bwf = 7; tick("nt7"); chk_cnt("nt7_c7", 7, 2);

    decode(10); tick("d10a"); decode(10); tick("d10b");
    decode(10); tick("ovf10"); chk_cnt("ovf10_c10", 10, 2);
    be = 1; bt = 1; bwf = 10; tick("flush10"); chk_cnt("flush10_c10", 10, 0);
    issue(0, 11); tick("udf11"); chk_cnt("udf11_c11", 11, 0);
`ifdef WF_OCC_ERR_CHECK_EN
    vectors++;
    assert (ovf_o[10] === 1'b1 && udf_o[11] === 1'b1) else begin
      miscompares++; $error("FAIL err_sticky obs=%b%b exp=11", ovf_o[10], udf_o[11]);
    end
`endif

    decode(2); bar = 1; tick("barrier"); chk_cnt("barrier_c2", 2, 0);
    decode(2); halt = 1; tick("halt"); chk_cnt("halt_c2", 2, 0);
    decode(45); tick("oor_dec");
    issue(0, 50); issue(1, 63); be = 1; bt = 1; bwf = 47; tick("oor_other");
    decode(5); tick("d5a"); decode(5); tick("d5b");
    rst = 1; decode(5); tick("rst_mid"); chk_cnt("rst_mid_c5", 5, 0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      dv = ($urandom_range(0, 3) != 0);
      halt = ($urandom_range(0, 9) == 0);
      bar = ($urandom_range(0, 9) == 0);
      wc = ($urandom_range(0, 9) == 0);
      dwf = ($urandom_range(0, 7) == 0) ? WF_ID_W'($urandom_range(0, 63)) : WF_ID_W'($urandom_range(0, 5));
      for (int p = 0; p < IP; p++) begin
        iv[p] = ($urandom_range(0, 2) == 0);
        iwf[p*WF_ID_W +: WF_ID_W] = ($urandom_range(0, 7) == 0) ?
          WF_ID_W'($urandom_range(0, 63)) : WF_ID_W'($urandom_range(0, 5));
      end
      be = ($urandom_range(0, 7) == 0);
      bt = $urandom_range(0, 1) == 1;
      bwf = WF_ID_W'($urandom_range(0, 7));
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
